axi_mem_slave: RTL
==================

AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h8000_0000, meaning the byte address of word 0.
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 4096, meaning the number of 32-bit words stored (power of two).
REQ-003 The block SHALL have parameter DELAY, default 3, meaning the extra response cycles inserted when AXI_MEM_RESP_DELAY_EN is defined (range 1..15).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have read-address ports: AXI_araddr input [31:0]; AXI_arvalid input 1; AXI_arready output 1.
REQ-007 The block SHALL have read-data ports: AXI_rdata output [31:0]; AXI_rvalid output 1; AXI_rready input 1.
REQ-008 The block SHALL have write-address ports: AXI_awaddr input [31:0]; AXI_awvalid input 1; AXI_awready output 1.
REQ-009 The block SHALL have write-data ports: AXI_wdata input [31:0]; AXI_wstrb input [3:0]; AXI_wvalid input 1; AXI_wready output 1.
REQ-010 The block SHALL have write-response ports: AXI_bresp output [1:0]; AXI_bvalid output 1; AXI_bready input 1.

Function
REQ-011 The block SHALL be a single-port word memory serving one transaction at a time, as downstream slave of the CPU AXI master port.
REQ-012 The FSM SHALL have states IDLE, WCOLLECT, RDLY, RRESP, WDLY, WRESP.
REQ-013 AXI_arready SHALL be 1 only in IDLE; an AR handshake latches the address and moves to RDLY.
REQ-014 In IDLE with AXI_arvalid=1, AXI_awready and AXI_wready SHALL be 0 (read priority on simultaneous requests).
REQ-015 In IDLE with AXI_arvalid=0, and in WCOLLECT, AXI_awready SHALL be 1 until an AW beat is held, and AXI_wready SHALL be 1 until a W beat is held.
REQ-016 AW and W beats SHALL be accepted in either order or in the same cycle; capture of the first beat only moves IDLE->WCOLLECT, while holding both moves to WDLY.
REQ-017 In WCOLLECT, AXI_arready SHALL be 0; a started write is never preempted by a read.
REQ-018 Word index SHALL be (addr - BASE_ADDR) >> 2; addr[1:0] SHALL be ignored; an address is in range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS.
REQ-019 A write SHALL update only the byte lanes whose wstrb bit is 1; wstrb=4'b0000 SHALL leave memory unchanged and respond OKAY.
REQ-020 An out-of-range write SHALL not modify memory and SHALL give AXI_bresp=2'b10 (SLVERR); otherwise AXI_bresp=2'b00.
REQ-021 An out-of-range read SHALL return AXI_rdata=32'h0000_0000.
REQ-022 The memory write SHALL commit on the edge that leaves WDLY; the memory read SHALL sample on the edge that leaves RDLY.
REQ-023 AXI_rvalid SHALL be 1 exactly in RRESP, and AXI_rdata SHALL be stable in RRESP until the handshake (AXI_rready=1); the handshake then moves to IDLE.
REQ-024 AXI_bvalid SHALL be 1 exactly in WRESP, with AXI_bresp stable; AXI_bready=1 SHALL move to IDLE.
REQ-025 A read issued in the cycle after a write response SHALL return the newly written data (no stale read).

Reset
REQ-026 With rst=0, the state SHALL go to IDLE immediately, the held-AW/W flags and delay counter SHALL clear, and every ready/valid output SHALL read 0, AXI_rdata 0 and AXI_bresp 0.
REQ-027 Reset mid-transaction SHALL drop the transaction with no response; memory contents SHALL not be reset, and a write not yet committed SHALL be lost.
REQ-028 The first request SHALL be acceptable on the first rising edge after rst is released.

Configuration
REQ-029 Without macro AXI_MEM_RESP_DELAY_EN, RDLY and WDLY SHALL last exactly 1 cycle: AXI_rvalid rises 2 cycles after the AR handshake edge, and AXI_bvalid 2 cycles after the edge holding both AW and W.
REQ-030 With AXI_MEM_RESP_DELAY_EN defined, RDLY and WDLY SHALL last 1+DELAY cycles via a 4-bit down-counter loaded on entry.

Verification
REQ-031 Reset, write 32'h1234_5678 to 32'h8000_0010 with wstrb=4'hF, then read 32'h8000_0010 -> bresp=2'b00, rdata=32'h1234_5678, rvalid at handshake+2 cycles (no macro).
REQ-032 Write 32'hAABB_CCDD with wstrb=4'b0101 over 32'h1234_5678 -> read returns 32'h12BB_56DD.
REQ-033 Drive W one cycle before AW, and separately AW and W together -> both complete with one bvalid each, and the memory holds the correct data.
REQ-034 Drive arvalid and awvalid/wvalid high in the same IDLE cycle -> the AR handshake occurs first, awready/wready stay 0 until rready completes the read, then the write completes.
REQ-035 Write to 32'h7FFF_FFFC and to BASE_ADDR+4*DEPTH_WORDS -> bresp=2'b10 and memory is unchanged; a read of the same addresses returns 0.
REQ-036 Hold rready=0 for 5 cycles in RRESP, then assert rst=0 -> rvalid holds with stable data, then drops to 0 immediately on reset; with the macro and DELAY=3, rvalid rises at handshake+5.

Source files
------------

// File: rtl/axi_mem_slave.sv
// Single-port AXI-Lite style word memory, one transaction at a time, read priority.
// Optional macro AXI_MEM_RESP_DELAY_EN stretches RDLY/WDLY to 1+DELAY cycles.
//
// state    | meaning
// IDLE     | accepting AR (priority) or AW/W beats
// WCOLLECT | one of AW/W held, waiting for the other
// RDLY     | read address held, memory sampled on exit
// RRESP    | rvalid high until rready
// WDLY     | AW and W held, memory written on exit
// WRESP    | bvalid high until bready
module axi_mem_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          DELAY       = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] AXI_araddr,
  input  logic        AXI_arvalid,
  output logic        AXI_arready,
  output logic [31:0] AXI_rdata,
  output logic        AXI_rvalid,
  input  logic        AXI_rready,
  input  logic [31:0] AXI_awaddr,
  input  logic        AXI_awvalid,
  output logic        AXI_awready,
  input  logic [31:0] AXI_wdata,
  input  logic [3:0]  AXI_wstrb,
  input  logic        AXI_wvalid,
  output logic        AXI_wready,
  output logic [1:0]  AXI_bresp,
  output logic        AXI_bvalid,
  input  logic        AXI_bready
);

  typedef enum logic [2:0] {IDLE, WCOLLECT, RDLY, RRESP, WDLY, WRESP} state_t;

`ifdef AXI_MEM_RESP_DELAY_EN
  localparam bit DLY_EN = 1'b1;
`else
  localparam bit DLY_EN = 1'b0;
`endif
  localparam logic [3:0]  DLY_LOAD = DLY_EN ? 4'(DELAY) : 4'd0;
  localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) * 33'd4;

  state_t      state, next_state;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  wstrb_q, cnt;
  logic [1:0]  bresp_q;
  logic        aw_held, w_held;
  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]      offset;
  logic             in_range, dly_done;
  logic [IDX_W-1:0] idx;
  logic             aw_hs, w_hs, got_aw, got_w;

  // Offset wraps for addresses below BASE_ADDR, so one unsigned compare covers both bounds
  assign offset   = addr_q - BASE_ADDR;
  assign in_range = {1'b0, offset} < SPAN;
  assign idx      = offset[IDX_W+1:2];
  assign dly_done = (cnt == 4'd0);

  assign aw_hs  = AXI_awvalid && AXI_awready;
  assign w_hs   = AXI_wvalid && AXI_wready;
  assign got_aw = aw_held || aw_hs;
  assign got_w  = w_held || w_hs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (AXI_arvalid)          next_state = RDLY;
        else if (got_aw && got_w) next_state = WDLY;
        else if (got_aw || got_w) next_state = WCOLLECT;
      end
      WCOLLECT: if (got_aw && got_w) next_state = WDLY;
      RDLY:     if (dly_done)        next_state = RRESP;
      RRESP:    if (AXI_rready)      next_state = IDLE;
      WDLY:     if (dly_done)        next_state = WRESP;
      WRESP:    if (AXI_bready)      next_state = IDLE;
      default:                       next_state = IDLE;
    endcase
  end

  always_comb begin
    AXI_arready = 1'b0;
    AXI_awready = 1'b0;
    AXI_wready  = 1'b0;
    AXI_rvalid  = 1'b0;
    AXI_bvalid  = 1'b0;
    case (state)
      IDLE: begin
        AXI_arready = 1'b1;
        AXI_awready = !AXI_arvalid && !aw_held;
        AXI_wready  = !AXI_arvalid && !w_held;
      end
      WCOLLECT: begin
        AXI_awready = !aw_held;
        AXI_wready  = !w_held;
      end
      RRESP:   AXI_rvalid = 1'b1;
      WRESP:   AXI_bvalid = 1'b1;
      default: ;
    endcase
    // Handshake outputs must read 0 for the whole time reset is held
    if (!rst) begin
      AXI_arready = 1'b0;
      AXI_awready = 1'b0;
      AXI_wready  = 1'b0;
      AXI_rvalid  = 1'b0;
      AXI_bvalid  = 1'b0;
    end
  end

  assign AXI_rdata = rdata_q;
  assign AXI_bresp = bresp_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      cnt     <= '0;
      rdata_q <= '0;
      bresp_q <= '0;
    end else begin
      if (state == IDLE && AXI_arvalid) addr_q <= AXI_araddr;
      else if (aw_hs)                   addr_q <= AXI_awaddr;
      if (w_hs) begin
        wdata_q <= AXI_wdata;
        wstrb_q <= AXI_wstrb;
      end
      aw_held <= (next_state == WCOLLECT) && got_aw;
      w_held  <= (next_state == WCOLLECT) && got_w;
      if ((next_state == RDLY || next_state == WDLY) && next_state != state)
        cnt <= DLY_LOAD;
      else if (!dly_done)
        cnt <= cnt - 4'd1;
      if (state == RDLY && dly_done)
        rdata_q <= in_range ? mem[idx] : 32'h0000_0000;
      if (state == WDLY && dly_done)
        bresp_q <= in_range ? 2'b00 : 2'b10;
    end
  end

  // Storage is deliberately not reset; a reset during WDLY forces IDLE so nothing commits
  always_ff @(posedge clk) begin
    if (rst && state == WDLY && dly_done && in_range) begin
      for (int b = 0; b < 4; b++)
        if (wstrb_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end

endmodule
